// File: rtl/aftab_isagu_seq.sv
// Trap-vector handler address generator: direct, vectored and
// (with AFTAB_ISAGU_TABLE_EN defined) memory-table handler lookup.
module aftab_isagu_seq #(
   parameter int len        = 32,
   parameter int causeWidth = 6,
   parameter int timeout    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [len-1:0]        tvecBase,
   input  logic [causeWidth-1:0] causeCode,
   input  logic                  isInterrupt,
   output logic                  busy,
   output logic                  valid,
   output logic [len-1:0]        startAddress,
   output logic [1:0]            modeTvec,
   output logic                  tableErr,
   output logic                  memRead,
   output logic [len-1:0]        memAddr,
   input  logic [len-1:0]        memData,
   input  logic                  memReady
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FETCH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, next_state;

   logic [len-3:0]        lat_base;
   logic [causeWidth-1:0] lat_cause;
   logic                  lat_int;
   logic [len-1:0]        base;
   logic [len-1:0]        cause_ext;
   logic [len-1:0]        vec_addr;
   logic                  vec_mode;
   logic                  table_mode;

   assign base      = {lat_base, 2'b00};
   assign cause_ext = len'(lat_cause);
   assign vec_addr  = base + (cause_ext << 2);
   assign vec_mode  = (modeTvec == 2'b01) && lat_int;
   assign busy      = (state != IDLE);
   assign valid     = (state == DONE);

`ifdef AFTAB_ISAGU_TABLE_EN
   localparam int cw = $clog2(timeout + 1);

   logic [cw-1:0]  tmo_cnt;
   logic           err_q;
   logic           expired;
   logic [len-1:0] tbl_addr;

   assign table_mode = (modeTvec == 2'b11);
   assign expired    = (tmo_cnt == cw'(1));
   assign tbl_addr   = base + cause_ext * len'(len / 8);
   assign memRead    = (state == FETCH);
   assign tableErr   = (state == DONE) && err_q;
`else
   logic unused_mem;

   assign table_mode = 1'b0;
   assign unused_mem = ^{memData, memReady};
   assign memRead    = 1'b0;
   assign memAddr    = '0;
   assign tableErr   = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state decode
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = CALC;
         CALC:    next_state = table_mode ? FETCH : DONE;
`ifdef AFTAB_ISAGU_TABLE_EN
         FETCH:   if (memReady || expired) next_state = DONE;
`else
         FETCH:   next_state = IDLE;
`endif
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latch and handler address datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_base     <= '0;
         lat_cause    <= '0;
         lat_int      <= 1'b0;
         modeTvec     <= 2'b00;
         startAddress <= '0;
`ifdef AFTAB_ISAGU_TABLE_EN
         memAddr      <= '0;
         tmo_cnt      <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  lat_base  <= tvecBase[len-1:2];
                  lat_cause <= causeCode;
                  lat_int   <= isInterrupt;
                  modeTvec  <= tvecBase[1:0];
               end
            end
            CALC: begin
`ifdef AFTAB_ISAGU_TABLE_EN
               err_q <= 1'b0;
               if (table_mode) begin
                  memAddr <= tbl_addr;
                  tmo_cnt <= cw'(timeout);
               end
`endif
               if (vec_mode)
                  startAddress <= vec_addr;
               else if (!table_mode)
                  startAddress <= base;
            end
`ifdef AFTAB_ISAGU_TABLE_EN
            FETCH: begin
               if (memReady) begin
                  startAddress <= {memData[len-1:1], 1'b0};
               end else if (expired) begin
                  startAddress <= base;
                  err_q        <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt - cw'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
